// File: rtl/display_scanner_pkg.sv
// rtl/display_scanner_pkg.sv - shared display constants and one-hot digit decode
package display_scanner_pkg;

    localparam int NUM_POS = 4;
    localparam int NIB_W   = 4;
    localparam int POS_W   = 2;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [NIB_W-1:0] nib_t;

    // Position index to active-high one-hot digit select
    function automatic logic [NUM_POS-1:0] onehot(input pos_t p);
        logic [NUM_POS-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/display_scanner_dwell_counter.sv
// rtl/display_scanner_dwell_counter.sv - per-digit dwell counter with terminal-count strobe
module dwell_counter #(
    parameter int DWELL = 50000,
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    // Next count: clear wins, otherwise count up and wrap at the last dwell cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit multiplexed display scanner with blanking and frame snapshot
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int GAP   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 lz_en,
    input  logic [15:0]          data,
    output logic [NUM_POS-1:0]   indicador,
    output logic [NIB_W-1:0]     valor,
    output logic                 frame_tick
);

    localparam int CNT_W = $clog2(DWELL);

    logic        run_q, run_d;
    pos_t        pos_q, pos_d;
    logic [15:0] data_q, data_d;
    logic        lz_q, lz_d;

    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             past_gap;
    logic             blank;
    logic             step;

    // Counter only advances while enabled and already running; dropping enable restarts it
    assign step = enable && run_q;

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (!enable),
        .inc   (step),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Anti-ghosting window at the start of each dwell; absent entirely when GAP is 0
    if (GAP == 0) begin : g_nogap
        assign past_gap = 1'b1;
    end else begin : g_gap
        localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP);
        assign past_gap = (cnt >= GAP_C);
    end

    // Next position, snapshot and run flag; snapshot refreshes only while halted or at frame wrap
    always_comb begin
        run_d  = enable;
        lz_d   = lz_en;
        pos_d  = pos_q;
        data_d = data_q;
        if (!enable) begin
            pos_d  = '0;
            data_d = data;
        end else if (run_q && tc) begin
            pos_d = pos_q + 1'b1;
            if (pos_q == pos_t'(NUM_POS - 1)) begin
                data_d = data;
            end
        end
    end

    // Leading-zero blank: this digit and every higher one are zero; digit 0 always shown
    always_comb begin
        blank = 1'b0;
        if (lz_q && (pos_q != '0)) begin
            blank = 1'b1;
            for (int i = 1; i < NUM_POS; i++) begin
                if ((i >= int'(pos_q)) && (data_q[i*NIB_W +: NIB_W] != '0)) begin
                    blank = 1'b0;
                end
            end
        end
    end

    // Scanner state registers; lz_en is registered so outputs depend on state only
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            pos_q  <= '0;
            data_q <= '0;
            lz_q   <= 1'b0;
        end else begin
            run_q  <= run_d;
            pos_q  <= pos_d;
            data_q <= data_d;
            lz_q   <= lz_d;
        end
    end

    assign indicador  = (run_q && past_gap && !blank) ? onehot(pos_q) : '0;
    assign valor      = data_q[{pos_q, 2'b00} +: NIB_W];
    assign frame_tick = run_q && (pos_q == pos_t'(NUM_POS - 1)) && tc;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        lz_en;
    logic [15:0] data;

    logic [3:0] ind0, val0, ind1, val1;
    logic       tick0, tick1;

    always #5 clk = ~clk;

    display_scanner #(.DWELL(4), .GAP(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en), .data(data),
        .indicador(ind0), .valor(val0), .frame_tick(tick0)
    );

    display_scanner #(.DWELL(2), .GAP(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en), .data(data),
        .indicador(ind1), .valor(val1), .frame_tick(tick1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elapsed time t within a frame of 4*D cycles; position and dwell offset derived from it
    int          dw[2] = '{4, 2};
    int          gp[2] = '{1, 0};
    bit          mrun[2];
    int          mt[2];
    logic [15:0] msnap[2];
    bit          mlz[2];

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mrun[m] = 0; mt[m] = 0; msnap[m] = 16'h0; mlz[m] = 0;
            end else begin
                if (!enable) begin
                    mt[m] = 0;
                    msnap[m] = data;
                end else if (mrun[m]) begin
                    if (mt[m] == 4*dw[m] - 1) begin
                        mt[m] = 0;
                        msnap[m] = data;
                    end else begin
                        mt[m] = mt[m] + 1;
                    end
                end
                mrun[m] = enable;
                mlz[m]  = lz_en;
            end
        end
    end

    function automatic int m_val(input int m);
        int p = mt[m] / dw[m];
        return (msnap[m] >> (4*p)) & 15;
    endfunction

    function automatic int m_ind(input int m);
        int p = mt[m] / dw[m];
        int c = mt[m] % dw[m];
        bit blank = mlz[m] && (p >= 1) && ((msnap[m] >> (4*p)) == 0);
        return (mrun[m] && (c >= gp[m]) && !blank) ? (1 << p) : 0;
    endfunction

    function automatic int m_tick(input int m);
        return (mrun[m] && (mt[m] == 4*dw[m] - 1)) ? 1 : 0;
    endfunction

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("u0_indicador", ind0, m_ind(0));
            chk("u0_valor", val0, m_val(0));
            chk("u0_frame_tick", tick0, m_tick(0));
            chk("u0_onehot", ($countones(ind0) <= 1), 1);
            chk("u1_indicador", ind1, m_ind(1));
            chk("u1_valor", val1, m_val(1));
            chk("u1_frame_tick", tick1, m_tick(1));
            chk("u1_onehot", ($countones(ind1) <= 1), 1);
            if (mrun[1] && !mlz[1]) chk("u1_never_dark", (ind1 != 0), 1);
        end
    end

    int exp_ind[16] = '{0,1,1,1, 0,2,2,2, 0,4,4,4, 0,8,8,8};
    int exp_val[8]  = '{4,3,2,1, 8,7,6,5};

    initial begin
        int ticks;
        logic [3:0] acc0, acc1;

        reset = 1'b1; enable = 1'b0; lz_en = 1'b0; data = 16'h0;
        @(negedge clk);
        chk_on = 1;
        chk("reset_ind", ind0, 0);
        chk("reset_valor", val0, 0);
        chk("reset_tick", tick0, 0);

        // Basic scan of 0x1234
        reset = 1'b0; data = 16'h1234;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("scan_ind", ind0, exp_ind[k]);
            chk("scan_valor", val0, 4 - k/4);
            chk("scan_tick", tick0, (k == 15) ? 1 : 0);
        end

        // Frame snapshot: data change at pos 1 only takes effect after the wrap
        ticks = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k % 4 == 0) chk("snap_valor", val0, exp_val[k/4]);
            if (tick0) ticks++;
            if (k == 4) data = 16'h5678;
        end
        chk("tick_count", ticks, 2);

        // Halt at pos 2, then restart with a full dwell on digit 0
        repeat (9) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("halt_ind", ind0, 0);
        chk("halt_valor", val0, 8);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_gap", ind0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("restart_dwell", ind0, 1);
        end
        @(negedge clk);
        chk("restart_next", ind0, 0);
        chk("restart_next_val", val0, 7);
        @(negedge clk);

        // Reset mid-dwell
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ind", ind0, 0);
        chk("midreset_valor", val0, 0);
        chk("midreset_tick", tick0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("postreset_valor", val0, 0);
        @(negedge clk);
        chk("postreset_ind", ind0, 1);

        // Leading-zero suppression
        enable = 1'b0; lz_en = 1'b1; data = 16'h0050;
        @(negedge clk);
        enable = 1'b1;
        acc0 = 0; acc1 = 0;
        repeat (17) begin
            @(negedge clk);
            acc0 |= ind0; acc1 |= ind1;
        end
        chk("lz_0050_u0", acc0, 4'b0011);
        chk("lz_0050_u1", acc1, 4'b0011);

        enable = 1'b0; data = 16'h0000;
        @(negedge clk);
        enable = 1'b1;
        acc0 = 0;
        repeat (17) begin
            @(negedge clk);
            acc0 |= ind0;
            if (ind0 == 4'b0001) chk("lz_0000_valor", val0, 0);
        end
        chk("lz_0000_u0", acc0, 4'b0001);

        enable = 1'b0; lz_en = 1'b0; data = 16'h0050;
        @(negedge clk);
        enable = 1'b1;
        acc0 = 0; acc1 = 0;
        repeat (17) begin
            @(negedge clk);
            acc0 |= ind0; acc1 |= ind1;
        end
        chk("nolz_u0", acc0, 4'b1111);
        chk("nolz_u1", acc1, 4'b1111);

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
